pmem_responder: RTL and testbench
=================================

Name: pmem_responder

Overview:
- Physical-memory-side responder for the cache's pmem interface: accepts 256-bit line reads and writes and returns pmem_resp after a fixed, parameterised latency.
- Backs the lines with a small on-chip line array; addresses beyond the array alias (wrap).
- Sits opposite the cache as its memory model in system benches; synthesizable so it can stand in for DRAM on FPGA.

Parameters:
- LINES, 16, number of 256-bit lines stored; power of two, minimum 2.
- LATENCY, 4, clock edges from request accept to the pmem_resp cycle; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pmem_address  input  32  line address; bits [4:0] ignored; index = address[5 +: log2(LINES)].
- pmem_wdata  input  256  write line data.
- pmem_read  input  1  read request, held by the initiator until pmem_resp.
- pmem_write  input  1  write request, held by the initiator until pmem_resp.
- pmem_rdata  output  256  read line data, valid in the pmem_resp cycle of a read.
- pmem_resp  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky flag: pmem_read and pmem_write were sampled high together in IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, pmem_resp=0, pmem_rdata=0, proto_err=0, all lines cleared to 0. Any in-flight request is discarded; no resp is issued after reset release.
- FSM states:
  - IDLE: on a rising edge with pmem_read|pmem_write high, latch index, op and wdata, load counter with LATENCY-1, go BUSY. If LATENCY==1, go RESP directly.
  - BUSY: decrement the counter each edge; at 0, go RESP.
  - RESP: pmem_resp=1 for exactly this cycle; next state IDLE.
- Latency: request sampled at edge t -> pmem_resp high in the cycle following edge t+LATENCY-1. Example: LATENCY=4, accept at edge 0, resp during cycle 4.
- Read: pmem_rdata is loaded from line[index] on the edge entering RESP and holds until the next read completes.
- Write: line[index] is updated with the latched wdata on the edge entering RESP; pmem_rdata is unchanged.
- Read and write sampled high together: treat as a write and set proto_err, which stays set until reset.
- Inputs are ignored outside IDLE. A request that drops or changes mid-operation still completes with the latched op, address and data. No abort.
- Back-to-back: a request held high in the cycle after RESP is accepted on the next edge (IDLE is entered, then samples). A one-cycle IDLE gap is the minimum turnaround.
- Aliasing: index wraps modulo LINES, so 0x0000_0000 and LINES*32 map to the same line.

Decomposition:
- Package pmem_pkg:
  - typedef line_t = logic [255:0];
  - enum pmem_state_t {IDLE, BUSY, RESP};
  - constant OFFSET_BITS = 5.
- One natural sub-module: pmem_line_array (LINES x line_t storage with write enable, clear-on-reset, combinational read).
- FSM and counter live in pmem_responder.

Test Plan:
- Reset, then read 0x0000_0040 with LATENCY=4 -> pmem_resp high exactly at cycle 4 after accept for one cycle; pmem_rdata=0.
- Write 0x0000_0060 with wdata={8{32'hDEADBEEF}}, then read 0x0000_0060 -> read returns {8{32'hDEADBEEF}}; resp pulse on each op.
- Aliasing, LINES=16: write 0x0000_0020 with data A, then read 0x0000_0220 -> returns A.
- Write-back then fill: write 0x100 (data B) immediately followed by a read of 0x200, request held through resp -> second accept one edge after RESP; read returns the line at 0x200, not B.
- pmem_read and pmem_write both high at address 0x80 with data C -> treated as a write, proto_err=1 and stays 1; a later read of 0x80 returns C.
- Reset mid-op: assert rst_n=0 during BUSY -> pmem_resp never pulses for that request; all lines read back 0 after release.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem responder memory model.
package pmem_pkg;

   // Byte offset within a 256-bit (32-byte) line.
   localparam int OFFSET_BITS = 5;

   typedef logic [255:0] line_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } pmem_state_t;

   // Even parity over one line, handy for storage integrity checking.
   function automatic logic line_parity(input line_t line);
      return ^line;
   endfunction

endpackage : pmem_pkg

// File: rtl/pmem_line_array.sv
// LINES x 256-bit line storage: one write port, one combinational read port,
// contents cleared by the asynchronous reset.
module pmem_line_array
   import pmem_pkg::*;
#(
   parameter int LINES = 16,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  line_t            wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output line_t            rdata_o
);

   line_t mem_q [LINES];

   // Line storage: cleared on reset, single-line update when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : pmem_line_array

// File: rtl/pmem_responder.sv
// Memory-side responder for the cache pmem interface. Accepts one line read
// or write in IDLE, waits a fixed LATENCY and pulses pmem_resp for one cycle.
// Storage indices wrap modulo LINES, so high address bits alias.
module pmem_responder
   import pmem_pkg::*;
#(
   parameter int LINES   = 16,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pmem_address,
   input  line_t       pmem_wdata,
   input  logic        pmem_read,
   input  logic        pmem_write,
   output line_t       pmem_rdata,
   output logic        pmem_resp,
   output logic        proto_err
);

   localparam int IDX_W = $clog2(LINES);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   pmem_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic             wr_q;
   line_t            wdata_q;
   line_t            rdata_q;
   logic             resp_q;
   logic             perr_q;

   logic             req_s;
   logic             enter_resp_s;
   logic [IDX_W-1:0] op_idx_s;
   logic             op_wr_s;
   line_t            op_wdata_s;
   logic             arr_we_s;
   line_t            arr_rdata_s;
   logic             unused_addr_s;

   // Offset bits and aliased upper bits do not select a line.
   assign unused_addr_s = ^{pmem_address[31:OFFSET_BITS+IDX_W], pmem_address[OFFSET_BITS-1:0]};

   assign req_s = pmem_read | pmem_write;

   // Decide whether this edge enters RESP; in IDLE that only happens for LATENCY==1.
   always_comb begin
      enter_resp_s = 1'b0;
      case (state_q)
         IDLE:    enter_resp_s = req_s && (LATENCY == 1);
         BUSY:    enter_resp_s = (cnt_q <= CNT_ONE);
         RESP:    enter_resp_s = 1'b0;
         default: enter_resp_s = 1'b0;
      endcase
   end

   // Operation fields: live inputs while IDLE (zero-wait case), latched copies otherwise.
   always_comb begin
      op_idx_s   = idx_q;
      op_wr_s    = wr_q;
      op_wdata_s = wdata_q;
      if (state_q == IDLE) begin
         op_idx_s   = pmem_address[OFFSET_BITS +: IDX_W];
         op_wr_s    = pmem_write;
         op_wdata_s = pmem_wdata;
      end else begin
         op_idx_s   = idx_q;
         op_wr_s    = wr_q;
         op_wdata_s = wdata_q;
      end
   end

   assign arr_we_s = enter_resp_s & op_wr_s;

   pmem_line_array #(
      .LINES (LINES),
      .IDX_W (IDX_W)
   ) u_lines (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (arr_we_s),
      .waddr_i (op_idx_s),
      .wdata_i (op_wdata_s),
      .raddr_i (op_idx_s),
      .rdata_o (arr_rdata_s)
   );

   // Request FSM with latency counter and registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         resp_q <= enter_resp_s;
         if (enter_resp_s && !op_wr_s) begin
            rdata_q <= arr_rdata_s;
         end
         case (state_q)
            IDLE: begin
               if (req_s) begin
                  idx_q   <= pmem_address[OFFSET_BITS +: IDX_W];
                  wr_q    <= pmem_write;
                  wdata_q <= pmem_wdata;
                  cnt_q   <= CNT_LOAD;
                  if (pmem_read && pmem_write) begin
                     perr_q <= 1'b1;
                  end
                  state_q <= (LATENCY == 1) ? RESP : BUSY;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q <= CNT_ONE) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pmem_rdata = rdata_q;
   assign pmem_resp  = resp_q;
   assign proto_err  = perr_q;

endmodule : pmem_responder

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder (LINES=16, LATENCY=4) using a line
// model and a queue of expected read data.
module tb_pmem_responder;
   import pmem_pkg::*;

   localparam int LINES   = 16;
   localparam int LATENCY = 4;
   localparam int TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pmem_address;
   line_t       pmem_wdata;
   logic        pmem_read;
   logic        pmem_write;
   line_t       pmem_rdata;
   logic        pmem_resp;
   logic        proto_err;

   int    checks   = 0;
   int    failures = 0;
   line_t model [LINES];
   line_t exp_q [$];
   line_t last_rd;

   pmem_responder #(.LINES(LINES), .LATENCY(LATENCY)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[OFFSET_BITS +: $clog2(LINES)]);
   endfunction

   // Drive one request, update the model / push expected read data, and wait
   // (bounded) for pmem_resp. lat counts rising edges until resp is seen.
   task automatic run_op(input logic [31:0] addr, input logic rd, input logic wr,
                         input line_t wd, input bit hold,
                         output int lat, output line_t data);
      pmem_address = addr;
      pmem_wdata   = wd;
      pmem_read    = rd;
      pmem_write   = wr;
      if (wr) model[idx_of(addr)] = wd;
      else    exp_q.push_back(model[idx_of(addr)]);
      lat  = 0;
      data = '0;
      for (int c = 0; c < TIMEOUT; c++) begin
         @(posedge clk); #1;
         lat++;
         if (pmem_resp === 1'b1) begin
            data = pmem_rdata;
            break;
         end
      end
      if (!hold) begin
         pmem_read  = 1'b0;
         pmem_write = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pmem_address = '0; pmem_wdata = '0; pmem_read = 1'b0; pmem_write = 1'b0;
      for (int i = 0; i < LINES; i++) model[i] = '0;
      last_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (pmem_resp !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b exp=0", pmem_resp); end
      checks++; if (pmem_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", pmem_rdata); end
      checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read_latency();
      int lat; line_t d, e;
      run_op(32'h0000_0040, 1'b1, 1'b0, '0, 1'b0, lat, d);
      e = exp_q.pop_front();
      checks++; if (lat != LATENCY) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", lat, LATENCY); end
      checks++; if (d !== e) begin failures++; $display("FAIL read_40_data got=%h exp=%h", d, e); end
      last_rd = e;
      @(posedge clk); #1;
      checks++; if (pmem_resp !== 1'b0) begin failures++; $display("FAIL resp_pulse_width got=%b exp=0", pmem_resp); end
   endtask

   task automatic test_write_read();
      int lat; line_t d, e, wd;
      wd = {8{32'hDEADBEEF}};
      run_op(32'h0000_0060, 1'b0, 1'b1, wd, 1'b0, lat, d);
      checks++; if (lat != LATENCY) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", lat, LATENCY); end
      checks++; if (pmem_rdata !== last_rd) begin failures++; $display("FAIL write_keeps_rdata got=%h exp=%h", pmem_rdata, last_rd); end
      @(posedge clk); #1;
      checks++; if (pmem_resp !== 1'b0) begin failures++; $display("FAIL write_resp_pulse got=%b exp=0", pmem_resp); end
      run_op(32'h0000_0060, 1'b1, 1'b0, '0, 1'b0, lat, d);
      e = exp_q.pop_front();
      checks++; if (lat != LATENCY) begin failures++; $display("FAIL read60_latency got=%0d exp=%0d", lat, LATENCY); end
      checks++; if (d !== e) begin failures++; $display("FAIL read_60_data got=%h exp=%h", d, e); end
      last_rd = e;
      @(posedge clk); #1;
   endtask

   task automatic test_alias();
      int lat; line_t d, e, a;
      a = {4{64'hA5A5_0123_4567_89AB}};
      run_op(32'h0000_0020, 1'b0, 1'b1, a, 1'b0, lat, d);
      @(posedge clk); #1;
      run_op(32'h0000_0220, 1'b1, 1'b0, '0, 1'b0, lat, d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL alias_data got=%h exp=%h", d, e); end
      last_rd = e;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat; line_t d, e, b, z;
      z = {16{16'h5AA5}};
      b = {8{32'hB0B0_1111}};
      run_op(32'h0000_0000, 1'b0, 1'b1, z, 1'b0, lat, d);
      @(posedge clk); #1;
      run_op(32'h0000_0100, 1'b0, 1'b1, b, 1'b1, lat, d);
      checks++; if (lat != LATENCY) begin failures++; $display("FAIL b2b_write_latency got=%0d exp=%0d", lat, LATENCY); end
      // Switch to the read while still in the RESP cycle and hold it.
      run_op(32'h0000_0200, 1'b1, 1'b0, '0, 1'b0, lat, d);
      e = exp_q.pop_front();
      checks++; if (lat != LATENCY + 1) begin failures++; $display("FAIL b2b_turnaround got=%0d exp=%0d", lat, LATENCY + 1); end
      checks++; if (d !== e) begin failures++; $display("FAIL b2b_read_data got=%h exp=%h", d, e); end
      last_rd = e;
      @(posedge clk); #1;
   endtask

   task automatic test_proto_err();
      int lat; line_t d, e, c;
      c = {8{32'hC0DE_CAFE}};
      checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_err_clear got=%b exp=0", proto_err); end
      run_op(32'h0000_0080, 1'b1, 1'b1, c, 1'b0, lat, d);
      checks++; if (lat != LATENCY) begin failures++; $display("FAIL both_latency got=%0d exp=%0d", lat, LATENCY); end
      checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_err_set got=%b exp=1", proto_err); end
      checks++; if (pmem_rdata !== last_rd) begin failures++; $display("FAIL both_keeps_rdata got=%h exp=%h", pmem_rdata, last_rd); end
      @(posedge clk); #1;
      run_op(32'h0000_0080, 1'b1, 1'b0, '0, 1'b0, lat, d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL both_read_back got=%h exp=%h", d, e); end
      checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_err_sticky got=%b exp=1", proto_err); end
      last_rd = e;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midop();
      int lat; int seen; line_t d, e;
      pmem_address = 32'h0000_0060; pmem_read = 1'b1; pmem_write = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0; pmem_read = 1'b0;
      for (int i = 0; i < LINES; i++) model[i] = '0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (pmem_resp === 1'b1) seen++;
         if (c == 2) rst_n = 1'b1;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midop_no_resp got=%0d exp=0", seen); end
      checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL midop_proto_cleared got=%b exp=0", proto_err); end
      checks++; if (pmem_rdata !== '0) begin failures++; $display("FAIL midop_rdata_cleared got=%h exp=0", pmem_rdata); end
      for (int i = 0; i < LINES; i++) begin
         run_op(32'(i * 32), 1'b1, 1'b0, '0, 1'b0, lat, d);
         e = exp_q.pop_front();
         checks++; if (d !== e || lat != LATENCY) begin failures++; $display("FAIL cleared_line%0d got=%h lat=%0d exp=%h lat=%0d", i, d, lat, e, LATENCY); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_write_read();
      test_alias();
      test_back_to_back();
      test_proto_err();
      test_reset_midop();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pmem_responder
